branch_sequencer: RTL
=====================

# branch_sequencer

Two-cycle branch controller for the RV32I core. It owns the program counter and drives the shared combinational branch unit: it latches the branch condition, the operands and the target, then evaluates the condition through the branch unit one cycle later. It commits the next PC, pulses a flush on taken transfers and traps misaligned targets. It sits between decode and the fetch address path and keeps per-core branch/taken statistics.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- TRAP_PC, 32'h0000_0100, PC loaded on a misaligned taken target
- clk  in  1  rising-edge clock (single clock domain)
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  decoded instruction present this cycle
- stall  in  1  freeze all state and counters this cycle
- BrOp  in  5  branch code of the decoded instruction, same encoding as the branch unit
- is_jalr  in  1  target is rs1+imm rather than pc+imm
- rs1, rs2  in  32  register operands
- imm  in  32  sign-extended branch/jump immediate
- bu_rs1, bu_rs2  out  32  operands to the branch unit
- bu_brop  out  5  condition code to the branch unit
- bu_taken  in  1  NextPCSrc returned by the branch unit
- pc  out  32  current program counter
- busy  out  1  high while in RESOLVE; decode must hold its instruction
- flush  out  1  one-cycle pulse: discard younger fetched instruction
- misalign  out  1  one-cycle pulse: taken target had bit 1 set
- br_cnt, taken_cnt  out  16  control-transfer and taken counters, saturating

## Operation
- Branch class: BrOp[4]==1 (unconditional) or BrOp[4:3]==01 (conditional). BrOp[4:3]==00 is a non-branch.
- FSM states: RUN, RESOLVE.
- RUN, instr_valid && !stall, non-branch: pc <= pc+4.
- RUN, instr_valid && !stall, branch class:
  - latch BrOp, rs1 and rs2.
  - latch target: is_jalr ? (rs1+imm) & ~32'h1 : pc+imm.
  - latch link = pc+4.
  - go to RESOLVE; pc holds.
- RUN, !instr_valid or stall: everything holds.
- RESOLVE, !stall:
  - br_cnt increments.
  - bu_taken=1 and target[1]==0: pc <= target, flush pulses, taken_cnt increments.
  - bu_taken=1 and target[1]==1: pc <= TRAP_PC, misalign pulses, flush pulses, taken_cnt unchanged.
  - bu_taken=0: pc <= link, no flush.
  - return to RUN in all three cases.
- RESOLVE, stall: state, latches and counters hold; bu_* stays driven.
- bu_rs1, bu_rs2 and bu_brop come from the latches in RESOLVE. In RUN, bu_brop=5'b00000 and bu_rs1=bu_rs2=0.
- instr_valid is ignored in RESOLVE; decode holds the instruction while busy=1.
- Arithmetic is 32-bit modulo 2^32: pc+4 and pc+imm wrap silently.
- Counters saturate at 16'hFFFF and never wrap.
- Reset values: pc=RESET_PC, state=RUN, busy=0, flush=0, misalign=0, bu_brop=0, bu_rs1=bu_rs2=0, br_cnt=taken_cnt=0.
- Reset asserted in RESOLVE abandons the branch: no flush, no counter update, pc=RESET_PC.
- rst has priority over stall.

## Timing
- Non-branch: pc updates at the edge ending the accepting cycle (1-cycle throughput).
- Branch accepted in cycle N (RUN) → RESOLVE in N+1.
- The branch unit is evaluated combinationally during N+1; bu_taken is sampled at the edge ending N+1.
- New pc, flush and misalign are visible in N+2, with the pulses registered and high for exactly N+2.
- busy is high exactly in N+1, plus any stalled cycles while in RESOLVE.
- Each stall cycle in RESOLVE extends busy by one cycle and delays the flush by one cycle.
- Back-to-back branches: the second may be accepted in N+2; its operands must reflect the updated pc.
- flush never asserts two cycles in a row.

## Test plan
- Reset: pc=RESET_PC, all outputs 0. Three non-branch instr_valid cycles → pc=0x0C, busy never high.
- BEQ (BrOp=01000) at pc=0x20, rs1=rs2=5, imm=0x40 → busy in N+1, pc=0x60 and flush=1 in N+2, br_cnt=1, taken_cnt=1.
- BLT (01100) at pc=0x20, rs1=0xFFFF_FFFF, rs2=1 → taken to pc+imm. Same operands with BLTU (01110) → pc=0x24, no flush.
- JALR (BrOp=10000, is_jalr=1) with rs1=0x101, imm=0 → pc=0x100. With rs1=0x102 → misalign=1, flush=1, pc=TRAP_PC.
- Stall held 3 cycles in RESOLVE → busy high 4 cycles, flush delayed 3 cycles, counters increment once. rst asserted mid-RESOLVE → pc=RESET_PC, no flush.
- Preload br_cnt=0xFFFE via 0xFFFE branches, then 2 more → saturates at 0xFFFF. Branch at pc=0xFFFF_FFFC with imm=8 → pc=0x4.

Source files
------------

// File: rtl/branch_sequencer.sv
// ---------------------------------------------------------------------------
// branch_sequencer
//
// Two-cycle branch controller for the RV32I core. Owns the program counter,
// accepts decoded instructions in RUN and, for control transfers, latches
// the condition code, operands, target and link address. The following
// cycle (RESOLVE) it presents the latched values to the shared combinational
// branch unit and commits the next PC from the returned taken flag.
//
// Parameters:
//   RESET_PC   PC value after reset
//   TRAP_PC    PC loaded when a taken target is misaligned (bit 1 set)
//   CNT_MAX    saturation value of the statistics counters
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   instr_valid     decoded instruction present (ignored in RESOLVE)
//   stall           freeze all state and counters this cycle
//   BrOp            branch code: [4]=1 unconditional, [4:3]=01 conditional
//   is_jalr         target is rs1+imm (bit 0 cleared) instead of pc+imm
//   rs1, rs2, imm   register operands and sign-extended immediate
//   bu_rs1/bu_rs2/bu_brop   operands and code to the branch unit
//   bu_taken        taken flag returned by the branch unit
//   pc              current program counter
//   busy            high in RESOLVE; decode holds its instruction
//   flush           one-cycle pulse on any taken transfer
//   misalign        one-cycle pulse when a taken target has bit 1 set
//   br_cnt, taken_cnt   saturating transfer / taken statistics
// ---------------------------------------------------------------------------
module branch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
   parameter logic [15:0] CNT_MAX  = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic        stall,
   input  logic [4:0]  BrOp,
   input  logic        is_jalr,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [31:0] imm,
   output logic [31:0] bu_rs1,
   output logic [31:0] bu_rs2,
   output logic [4:0]  bu_brop,
   input  logic        bu_taken,
   output logic [31:0] pc,
   output logic        busy,
   output logic        flush,
   output logic        misalign,
   output logic [15:0] br_cnt,
   output logic [15:0] taken_cnt
);

   typedef enum logic {
      RUN     = 1'b0,
      RESOLVE = 1'b1
   } state_t;

   state_t      state, state_nx;

   logic [4:0]  brop_q;
   logic [31:0] rs1_q;
   logic [31:0] rs2_q;
   logic [31:0] target_q;
   logic [31:0] link_q;

   logic        is_branch;
   logic        accept;
   logic        resolve;
   logic [31:0] jalr_sum;
   logic [31:0] target_d;

   assign is_branch = BrOp[4] | (BrOp[4:3] == 2'b01);
   assign accept    = (state == RUN) && instr_valid && !stall;
   assign resolve   = (state == RESOLVE) && !stall;

   // JALR clears bit 0 of the sum; bit 1 is kept so a misaligned target
   // can still be detected at resolve time.
   assign jalr_sum  = rs1 + imm;
   assign target_d  = is_jalr ? {jalr_sum[31:1], 1'b0} : (pc + imm);

   // NOTE: every output of this block gets a default first so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      bu_brop  = 5'b00000;
      bu_rs1   = 32'h0;
      bu_rs2   = 32'h0;
      case (state)
         RUN: begin
            if (accept && is_branch)
               state_nx = RESOLVE;
         end
         RESOLVE: begin
            busy    = 1'b1;
            bu_brop = brop_q;
            bu_rs1  = rs1_q;
            bu_rs2  = rs2_q;
            if (!stall)
               state_nx = RUN;
         end
         default: state_nx = RUN;
      endcase
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         pc        <= RESET_PC;
         flush     <= 1'b0;
         misalign  <= 1'b0;
         br_cnt    <= 16'h0;
         taken_cnt <= 16'h0;
         brop_q    <= 5'b00000;
         rs1_q     <= 32'h0;
         rs2_q     <= 32'h0;
         target_q  <= 32'h0;
         link_q    <= 32'h0;
      end else begin
         state    <= state_nx;
         // Pulses are cleared every cycle, stall included, so they are
         // never high for more than the one cycle after resolution.
         flush    <= 1'b0;
         misalign <= 1'b0;

         if (accept) begin
            if (is_branch) begin
               brop_q   <= BrOp;
               rs1_q    <= rs1;
               rs2_q    <= rs2;
               target_q <= target_d;
               link_q   <= pc + 32'd4;
            end else begin
               pc <= pc + 32'd4;
            end
         end

         if (resolve) begin
            if (br_cnt != CNT_MAX)
               br_cnt <= br_cnt + 16'd1;
            if (bu_taken) begin
               flush <= 1'b1;
               if (target_q[1]) begin
                  pc       <= TRAP_PC;
                  misalign <= 1'b1;
               end else begin
                  pc <= target_q;
                  if (taken_cnt != CNT_MAX)
                     taken_cnt <= taken_cnt + 16'd1;
               end
            end else begin
               pc <= link_q;
            end
         end
      end
   end

endmodule
